// File: rtl/pll_reset_sequencer.sv
// Post-PLL reset sequencer: waits for a stable lock, releases the peripheral
// reset, then the CPU reset; a debounced button or lock loss reasserts both.
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES     = 4800,
  parameter int PERIPH_TO_CPU_CYCLES   = 16,
  parameter int BUTTON_DEBOUNCE_CYCLES = 48000,
  parameter int CNT_WIDTH              = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       button,
  output logic       periph_reset,
  output logic       cpu_reset,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    STABLE     = 3'd1,
    REL_PERIPH = 3'd2,
    RUN        = 3'd3,
    LOST       = 3'd4,
    HOLD       = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] STABLE_MAX   = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_MAX      = CNT_WIDTH'(PERIPH_TO_CPU_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DEBOUNCE_MAX = CNT_WIDTH'(BUTTON_DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

  state_t               cur;
  state_t               nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [CNT_WIDTH-1:0] db_cnt;
  logic                 lock_meta;
  logic                 lock_s;
  logic                 btn_meta;
  logic                 btn_s;
  logic                 btn_db;
  logic                 loss_event;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      btn_meta  <= 1'b0;
      btn_s     <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      btn_meta  <= button;
      btn_s     <= btn_meta;
    end
  end

  // The debounced level only flips after btn_s has disagreed with it for the full window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DEBOUNCE_MAX) begin
      db_cnt <= '0;
      btn_db <= ~btn_db;
    end else begin
      db_cnt <= db_cnt + CNT_ONE;
    end
  end

  always_comb begin
    nxt        = cur;
    cnt_nxt    = '0;
    loss_event = 1'b0;
    case (cur)
      WAIT_LOCK: begin
        if (lock_s && !btn_db) nxt = STABLE;
      end
      STABLE: begin
        if (!lock_s)                nxt = WAIT_LOCK;
        else if (btn_db)            nxt = HOLD;
        else if (cnt == STABLE_MAX) nxt = REL_PERIPH;
        else                        cnt_nxt = cnt + CNT_ONE;
      end
      REL_PERIPH: begin
        if (!lock_s)             nxt = WAIT_LOCK;
        else if (btn_db)         nxt = HOLD;
        else if (cnt == GAP_MAX) nxt = RUN;
        else                     cnt_nxt = cnt + CNT_ONE;
      end
      RUN: begin
        if (!lock_s) begin
          nxt        = LOST;
          loss_event = 1'b1;
        end else if (btn_db) begin
          nxt = HOLD;
        end
      end
      LOST:    nxt = WAIT_LOCK;
      HOLD:    if (!btn_db) nxt = WAIT_LOCK;
      default: nxt = WAIT_LOCK;
    endcase
  end

  // Reset outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur             <= WAIT_LOCK;
      cnt             <= '0;
      periph_reset    <= 1'b1;
      cpu_reset       <= 1'b1;
      ready           <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      cur          <= nxt;
      cnt          <= cnt_nxt;
      periph_reset <= !((nxt == REL_PERIPH) || (nxt == RUN));
      cpu_reset    <= (nxt != RUN);
      ready        <= (nxt == RUN);
      if (loss_event && (lock_loss_count != 8'hFF))
        lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised self-checking bench for pll_reset_sequencer; expected timing is
// derived from edge arithmetic relative to the lock/button capture edges.
module tb_pll_reset_sequencer;

  localparam int LS = 8;
  localparam int PG = 4;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       button = 1'b0;
  logic       periph_reset;
  logic       cpu_reset;
  logic       ready;
  logic [2:0] state;
  logic [7:0] lock_loss_count;

  int n_checks = 0;
  int n_fails = 0;
  int model_losses = 0;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(LS),
    .PERIPH_TO_CPU_CYCLES(PG),
    .BUTTON_DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pll_lock(pll_lock),
    .button(button),
    .periph_reset(periph_reset),
    .cpu_reset(cpu_reset),
    .ready(ready),
    .state(state),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      if (!cpu_reset && periph_reset) begin
        n_fails++;
        $display("[TB] FAIL invariant at %0t: cpu_reset=%b periph_reset=%b, required periph_reset=0", $time, cpu_reset, periph_reset);
      end
    end
  end

  // {state, periph_reset, cpu_reset, ready} at edge T+m after lock capture at T
  function automatic logic [5:0] expected_release(input int m);
    if (m < 2)               return {3'd0, 1'b1, 1'b1, 1'b0};
    else if (m < LS + 2)     return {3'd1, 1'b1, 1'b1, 1'b0};
    else if (m < LS + PG + 2) return {3'd2, 1'b0, 1'b1, 1'b0};
    else                     return {3'd3, 1'b0, 1'b0, 1'b1};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_sequence(input int from_m, input int to_m, input string tag);
    logic [5:0] exp_v;
    logic [5:0] got;
    for (int m = from_m; m <= to_m; m++) begin
      tick();
      exp_v = expected_release(m);
      got = {state, periph_reset, cpu_reset, ready};
      n_checks++;
      if (got !== exp_v) begin
        n_fails++;
        $display("[TB] FAIL %s edge T+%0d: got state=%0d periph=%b cpu=%b ready=%b, required state=%0d periph=%b cpu=%b ready=%b",
                 tag, m, got[5:3], got[2], got[1], got[0], exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
    n_checks++;
    if (lock_loss_count !== 8'(model_losses)) begin
      n_fails++;
      $display("[TB] FAIL %s count: got %0d, required %0d", tag, lock_loss_count, model_losses);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pll_lock = 1'b0;
    button = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({state, periph_reset, cpu_reset, ready, lock_loss_count} !== {3'd0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
      n_fails++;
      $display("[TB] FAIL reset_values: got state=%0d periph=%b cpu=%b ready=%b count=%0d, required 0 1 1 0 0",
               state, periph_reset, cpu_reset, ready, lock_loss_count);
    end
    reset = 1'b0;
    model_losses = 0;
    repeat (4) tick();
    n_checks++;
    if ({state, periph_reset, cpu_reset, ready} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL idle_no_lock: got state=%0d periph=%b cpu=%b, required state=0 periph=1 cpu=1", state, periph_reset, cpu_reset);
    end
  endtask

  task automatic test_power_up();
    pll_lock = 1'b1;
    release_sequence(0, LS + PG + 4, "power_up");
  endtask

  task automatic test_lock_glitch();
    pll_lock = 1'b0;
    repeat (6) tick();
    model_losses = sat_inc(model_losses);
    pll_lock = 1'b1;
    release_sequence(0, 4, "glitch_pre");
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    n_checks++;
    if (state !== 3'd1) begin
      n_fails++;
      $display("[TB] FAIL glitch_still_stable: got state=%0d, required 1", state);
    end
    tick();
    n_checks++;
    if ({state, periph_reset, cpu_reset, ready, lock_loss_count} !== {3'd0, 1'b1, 1'b1, 1'b0, 8'(model_losses)}) begin
      n_fails++;
      $display("[TB] FAIL glitch_back_to_wait: got state=%0d periph=%b cpu=%b count=%0d, required state=0 periph=1 cpu=1 count=%0d",
               state, periph_reset, cpu_reset, lock_loss_count, model_losses);
    end
    release_sequence(2, LS + PG + 4, "glitch_restart");
  endtask

  task automatic test_lock_loss(input int iterations);
    logic [5:0] exp_v;
    int         exp_count;
    for (int i = 0; i < iterations; i++) begin
      repeat ($urandom_range(0, 6)) tick();
      pll_lock = 1'b0;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (k < 2) begin
          exp_v = {3'd3, 1'b0, 1'b0, 1'b1};
          exp_count = model_losses;
        end else begin
          exp_v = (k == 2) ? {3'd4, 1'b1, 1'b1, 1'b0} : {3'd0, 1'b1, 1'b1, 1'b0};
          exp_count = sat_inc(model_losses);
        end
        n_checks++;
        if ({state, periph_reset, cpu_reset, ready, lock_loss_count} !== {exp_v, 8'(exp_count)}) begin
          n_fails++;
          $display("[TB] FAIL loss_%0d edge L+%0d: got state=%0d resets=%b%b count=%0d, required state=%0d resets=%b%b count=%0d",
                   i, k, state, periph_reset, cpu_reset, lock_loss_count, exp_v[5:3], exp_v[2], exp_v[1], exp_count);
        end
      end
      model_losses = sat_inc(model_losses);
      pll_lock = 1'b1;
      release_sequence(0, LS + PG + 2, "relock");
    end
  endtask

  task automatic test_button_glitch();
    button = 1'b1;
    repeat ($urandom_range(1, 3)) tick();
    button = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_checks++;
      if ({state, periph_reset, cpu_reset, ready} !== {3'd3, 1'b0, 1'b0, 1'b1}) begin
        n_fails++;
        $display("[TB] FAIL button_glitch cycle %0d: got state=%0d periph=%b cpu=%b, required state=3 periph=0 cpu=0", k, state, periph_reset, cpu_reset);
      end
    end
  endtask

  task automatic test_button_hold();
    int         len;
    logic [5:0] exp_v;
    len = $urandom_range(6, 14);
    button = 1'b1;
    for (int k = 0; k <= len + DB + LS + PG + 4; k++) begin
      if (k == len) button = 1'b0;
      tick();
      if (k < DB + 2)            exp_v = {3'd3, 1'b0, 1'b0, 1'b1};
      else if (k < len + DB + 2) exp_v = {3'd5, 1'b1, 1'b1, 1'b0};
      else                       exp_v = expected_release(k - len - DB - 1);
      n_checks++;
      if ({state, periph_reset, cpu_reset, ready} !== exp_v) begin
        n_fails++;
        $display("[TB] FAIL button_hold len=%0d edge B+%0d: got state=%0d periph=%b cpu=%b ready=%b, required state=%0d periph=%b cpu=%b ready=%b",
                 len, k, state, periph_reset, cpu_reset, ready, exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_simultaneous();
    button = 1'b1;
    repeat (4) tick();
    pll_lock = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (state !== 3'd3) begin
      n_fails++;
      $display("[TB] FAIL simul_pre: got state=%0d, required 3", state);
    end
    tick();
    model_losses = sat_inc(model_losses);
    n_checks++;
    if ({state, periph_reset, cpu_reset, lock_loss_count} !== {3'd4, 1'b1, 1'b1, 8'(model_losses)}) begin
      n_fails++;
      $display("[TB] FAIL simul_lost: got state=%0d resets=%b%b count=%0d, required state=4 resets=11 count=%0d",
               state, periph_reset, cpu_reset, lock_loss_count, model_losses);
    end
    tick();
    button = 1'b0;
    repeat (12) tick();
    n_checks++;
    if ({state, periph_reset, cpu_reset, lock_loss_count} !== {3'd0, 1'b1, 1'b1, 8'(model_losses)}) begin
      n_fails++;
      $display("[TB] FAIL simul_wait: got state=%0d resets=%b%b count=%0d, required state=0 resets=11 count=%0d",
               state, periph_reset, cpu_reset, lock_loss_count, model_losses);
    end
    pll_lock = 1'b1;
    release_sequence(0, LS + PG + 2, "simul_relock");
  endtask

  task automatic test_rel_periph_drop();
    logic [5:0] exp_v;
    pll_lock = 1'b0;
    repeat (6) tick();
    model_losses = sat_inc(model_losses);
    pll_lock = 1'b1;
    release_sequence(0, LS + PG - 1, "rel_drop_pre");
    pll_lock = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_v = (k < 2) ? {3'd2, 1'b0, 1'b1, 1'b0} : {3'd0, 1'b1, 1'b1, 1'b0};
      n_checks++;
      if ({state, periph_reset, cpu_reset, ready, lock_loss_count} !== {exp_v, 8'(model_losses)}) begin
        n_fails++;
        $display("[TB] FAIL rel_drop edge +%0d: got state=%0d periph=%b cpu=%b count=%0d, required state=%0d periph=%b cpu=%b count=%0d",
                 k, state, periph_reset, cpu_reset, lock_loss_count, exp_v[5:3], exp_v[2], exp_v[1], model_losses);
      end
    end
  endtask

  task automatic test_async_reset();
    pll_lock = 1'b1;
    release_sequence(0, LS + 3, "async_pre");
    #3;
    reset = 1'b1;
    #1;
    model_losses = 0;
    n_checks++;
    if ({state, periph_reset, cpu_reset, ready, lock_loss_count} !== {3'd0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
      n_fails++;
      $display("[TB] FAIL async_reset: got state=%0d periph=%b cpu=%b ready=%b count=%0d, required 0 1 1 0 0",
               state, periph_reset, cpu_reset, ready, lock_loss_count);
    end
    repeat (2) tick();
    reset = 1'b0;
    release_sequence(0, LS + PG + 4, "after_reset");
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_loss(1);
    test_lock_glitch();
    test_button_glitch();
    test_button_hold();
    test_simultaneous();
    test_lock_loss(260);
    test_rel_periph_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
